// File: rtl/rv_core_pkg.sv
// Shared types for the RV32I core front end.
//   RESET_VECTOR_DFLT : default PC of the first fetch after reset
//   INST_W            : instruction word width
//   fetch_state_e     : fetch sequencer states
//   fetch_entry_t     : buffered instruction word and its PC
package rv_core_pkg;
  localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;
  localparam int          INST_W            = 32;

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [31:0]       pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t feeding the decode stage.
// Ports: clk/rst_n (async active-low), push_i/push_data_i, pop_i, flush_i,
//        head_o (oldest entry), count_o, empty_o, full_o.
// Flush wins over push and pop in the same cycle. Push on full and pop on
// empty are ignored. DEPTH must be a power of 2 so the pointers wrap freely.
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction fetch stage: PC generation, IM request issue with a
// credit limit, in-order instruction buffer towards decode, and redirect
// handling that discards stale in-flight IM responses.
// Ports: clk, rst_n (async active-low)
//        im_req_valid/im_req_ready/im_addr : IM request channel
//        im_rsp_valid/im_rdata              : IM in-order response
//        inst_valid/inst_ready/inst_data/inst_pc : decode handshake
//        redirect_valid/redirect_pc         : branch/jump redirect pulse
// Optional (macro FETCH_PERF_EN): perf_fetch_cnt, perf_drop_cnt counters.
module if_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d, out_after_rsp;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  fifo_head;
  logic [CW:0]   credit_used;
  logic          req_fire, rsp_keep;
  logic [31:0]   redir_pc;
  logic          unused_redir_lsbs;

  assign unused_redir_lsbs = ^redirect_pc[1:0];
  assign redir_pc          = {redirect_pc[31:2], 2'b00};

  // Requests in flight plus buffered words never exceed the FIFO size, so
  // every response has a slot waiting for it.
  assign credit_used  = {1'b0, out_q} + {1'b0, fifo_count};
  assign im_req_valid = (state_q == FETCH) & ~redirect_valid
                      & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign im_addr      = pc_q;
  assign req_fire     = im_req_valid & im_req_ready;
  assign rsp_keep     = im_rsp_valid & (state_q == FETCH) & ~redirect_valid;

  // Outstanding count once this cycle's response retires; decides whether a
  // redirect still has stale responses to swallow.
  assign out_after_rsp = out_q - CW'(im_rsp_valid);

  always_comb begin
    state_d  = state_q;
    pc_d     = req_fire ? pc_q + 32'd4 : pc_q;
    rsp_pc_d = rsp_keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
    out_d    = out_q + CW'(req_fire) - CW'(im_rsp_valid);
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DRAIN:   if (out_after_rsp == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase
    if (redirect_valid) begin
      pc_d     = redir_pc;
      rsp_pc_d = redir_pc;
      if (state_q != BOOT)
        state_d = (out_after_rsp != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      rsp_pc_q <= RESET_VECTOR;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (rsp_keep & ~fifo_full),
    .push_data_i('{data: im_rdata, pc: rsp_pc_q}),
    .pop_i      (inst_valid & inst_ready),
    .flush_i    (redirect_valid),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign inst_valid = ~fifo_empty;
  assign inst_data  = fifo_head.data;
  assign inst_pc    = fifo_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (rsp_keep)                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (im_rsp_valid & ~rsp_keep) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 1-cycle IM model and a scoreboard
// of expected {data, pc} entries. Build with FETCH_PERF_EN to cover counters.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_req_valid, im_req_ready;
  logic [31:0] im_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_VECTOR(32'h0), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .im_req_valid  (im_req_valid),
    .im_req_ready  (im_req_ready),
    .im_addr       (im_addr),
    .im_rsp_valid  (im_rsp_valid),
    .im_rdata      (im_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt (perf_drop_cnt),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  int          n_chk = 0, n_pass = 0;
  logic [63:0] pend_q [$];   // {epoch, addr} of accepted requests
  logic [63:0] exp_q  [$];   // {data, pc} expected out of the buffer
  int          epoch, kept, dropped, pops;
  logic [31:0] exp_pc;
  bit          redir, hold, rdy;
  logic [31:0] redir_pc;
  logic        s_req_v;
  logic [31:0] s_addr;
  bit          watch200, seen200, saw0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // One clock: drive at negedge, sample 1 time unit later, then advance the
  // reference model by what the coming posedge will do.
  task automatic tick();
    logic [63:0] e, h;
    bit rsp_now, keep;
    e = '0;
    @(negedge clk);
    rsp_now = !hold && pend_q.size() != 0;
    if (rsp_now) begin
      e = pend_q.pop_front();
      im_rsp_valid = 1'b1;
      im_rdata     = mem_word(e[31:0]);
    end else begin
      im_rsp_valid = 1'b0;
      im_rdata     = 32'hDEAD_BEEF;
    end
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    inst_ready     = rdy;
    im_req_ready   = 1'b1;
    #1;
    s_req_v = im_req_valid;
    s_addr  = im_addr;
    chk("inst_valid", inst_valid, 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk("inst_data", inst_data, h[63:32]);
      chk("inst_pc", inst_pc, h[31:0]);
      if (inst_valid && inst_ready && !redir) begin
        void'(exp_q.pop_front());
        pops++;
        if (watch200 && inst_pc[31:4] == 28'h20) seen200 = 1;
        if (inst_pc == 32'h0) saw0 = 1;
      end
    end
    keep = rsp_now && (e[63:32] == 32'(epoch)) && !redir;
    if (rsp_now) begin
      if (keep) kept++;
      else dropped++;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_pc = {redir_pc[31:2], 2'b00};
    end
    if (keep) exp_q.push_back({mem_word(e[31:0]), e[31:0]});
    if (im_req_valid && im_req_ready) begin
      chk("im_addr", im_addr, exp_pc);
      pend_q.push_back({32'(epoch), exp_pc});
      exp_pc = exp_pc + 32'd4;
    end
    chk("credit", 32'((pend_q.size() + exp_q.size()) <= 2), 32'd1);
  endtask

  task automatic gather2();
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) tick();
    chk("two_in_flight", 32'(pend_q.size()), 32'd2);
  endtask

  initial begin
    rst_n = 1'b1; im_req_ready = 1'b1; im_rsp_valid = 1'b0; im_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    redir = 0; hold = 0; rdy = 1; redir_pc = '0;
    epoch = 0; kept = 0; dropped = 0; pops = 0; exp_pc = 32'h0;
    watch200 = 0; seen200 = 0; saw0 = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(im_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    rst_n = 1'b1;
    #1 chk("boot_no_req", 32'(im_req_valid), 32'd0);

    // Streaming fetch from the reset vector
    tick();
    chk("first_req", 32'(s_req_v), 32'd1);
    chk("first_addr", s_addr, 32'h0);
    repeat (11) tick();
    chk("stream_pops", 32'(pops >= 6), 32'd1);

    // Decode stall: credits exhaust, nothing lost after release
    rdy = 0;
    repeat (10) tick();
    chk("stall_no_req", 32'(s_req_v), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    rdy = 1;
    repeat (8) tick();

    // Two in flight, redirect, both responses dropped while draining
    hold = 1;
    gather2();
    redir = 1; redir_pc = 32'h200;
    tick();
    redir = 0; hold = 0;
    tick(); chk("drain1_no_req", 32'(s_req_v), 32'd0);
    tick(); chk("drain2_no_req", 32'(s_req_v), 32'd0);
    tick();
    chk("resume_req", 32'(s_req_v), 32'd1);
    chk("resume_addr", s_addr, 32'h200);
    tick();
    tick();
    chk("first_pc_after_redirect", inst_pc, 32'h200);
    repeat (3) tick();

    // Redirect coinciding with the last outstanding response
    for (int i = 0; i < 10 && pend_q.size() != 1; i++) tick();
    chk("one_in_flight", 32'(pend_q.size()), 32'd1);
    redir = 1; redir_pc = 32'h203;
    tick();
    redir = 0;
    tick();
    chk("direct_fetch_req", 32'(s_req_v), 32'd1);
    chk("direct_fetch_addr", s_addr, 32'h200);
    repeat (4) tick();

    // Second redirect while draining replaces the first target
    hold = 1;
    gather2();
    redir = 1; redir_pc = 32'h203;
    tick();
    watch200 = 1; seen200 = 0;
    redir_pc = 32'h400;
    tick();
    redir = 0; hold = 0;
    tick(); chk("dd1_no_req", 32'(s_req_v), 32'd0);
    tick(); chk("dd2_no_req", 32'(s_req_v), 32'd0);
    tick();
    chk("dd_resume_addr", s_addr, 32'h400);
    repeat (8) tick();
    chk("no_0x200_after_redirect", 32'(seen200), 32'd0);
    watch200 = 0;

    // PC wraps past 2^32
    redir = 1; redir_pc = 32'hFFFF_FFF8;
    tick();
    redir = 0; saw0 = 0;
    repeat (10) tick();
    chk("pc_wrap_zero_seen", 32'(saw0), 32'd1);

`ifdef FETCH_PERF_EN
    #5;
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'(kept));
    chk("perf_drop_cnt", perf_drop_cnt, 32'(dropped));
`endif

    // Reset in the middle of traffic with words buffered
    rdy = 0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_req_valid", 32'(im_req_valid), 32'd0);
    chk("midrst_inst_pc", inst_pc, 32'd0);
    chk("midrst_inst_data", inst_data, 32'd0);
`ifdef FETCH_PERF_EN
    chk("midrst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("midrst_perf_drop", perf_drop_cnt, 32'd0);
`endif
    pend_q.delete(); exp_q.delete();
    exp_pc = 32'h0; kept = 0; dropped = 0; epoch++;
    im_rsp_valid = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_boot", 32'(im_req_valid), 32'd0);
    rdy = 1;
    tick();
    chk("post_rst_addr", s_addr, 32'h0);
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
